// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts an n-bit word over valid/ready
// and emits it one bit per clock on sout, streaming back-to-back words without gaps.
module piso_serializer #(
    parameter int n         = 5,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] I,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         last
);

    localparam int CW = $clog2(n) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t          r_state;
    logic [n-1:0]    r_sh;
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [n-1:0]    w_sh_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_busy;
    logic            w_cnt_last;
    logic            w_accept;
    logic            w_out_bit;

    assign w_busy     = (r_state == ST_SHIFT);
    assign w_cnt_last = (r_cnt == CW'(n - 1));

    // Ready on the final bit as well, so the next word follows with no bubble.
    assign load_ready = !reset && (!w_busy || w_cnt_last);
    assign w_accept   = load_valid && load_ready;

    assign w_out_bit  = (MSB_FIRST != 0) ? r_sh[n-1] : r_sh[0];
    assign sout_valid = w_busy;
    assign sout       = w_busy ? w_out_bit : 1'b0;
    assign last       = w_busy && w_cnt_last;

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        if (w_accept) begin
            w_state_nxt = ST_SHIFT;
            w_sh_nxt    = I;
            w_cnt_nxt   = '0;
        end else if (w_busy) begin
            if (w_cnt_last) begin
                w_state_nxt = ST_IDLE;
                w_sh_nxt    = '0;
                w_cnt_nxt   = '0;
            end else begin
                w_sh_nxt  = (MSB_FIRST != 0) ? (r_sh << 1) : (r_sh >> 1);
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: n=5 MSB-first, n=5 LSB-first and n=1
// instances share one clock and reset; expected bit streams are hand-derived.
module tb_piso_serializer;

    logic       clk;
    logic       rst;

    logic [4:0] a_I, b_I;
    logic [0:0] c_I;
    logic       a_lv, b_lv, c_lv;
    logic       a_lr, b_lr, c_lr;
    logic       a_so, b_so, c_so;
    logic       a_sv, b_sv, c_sv;
    logic       a_ls, b_ls, c_ls;

    int n_tests = 0;
    int n_fail  = 0;

    piso_serializer #(.n(5), .MSB_FIRST(1)) u_a (
        .clk(clk), .reset(rst), .I(a_I), .load_valid(a_lv), .load_ready(a_lr),
        .sout(a_so), .sout_valid(a_sv), .last(a_ls)
    );

    piso_serializer #(.n(5), .MSB_FIRST(0)) u_b (
        .clk(clk), .reset(rst), .I(b_I), .load_valid(b_lv), .load_ready(b_lr),
        .sout(b_so), .sout_valid(b_sv), .last(b_ls)
    );

    piso_serializer #(.n(1), .MSB_FIRST(1)) u_c (
        .clk(clk), .reset(rst), .I(c_I), .load_valid(c_lv), .load_ready(c_lr),
        .sout(c_so), .sout_valid(c_sv), .last(c_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {sout, sout_valid, last, load_ready} of the selected instance
    function automatic logic [3:0] outs(input int sel);
        case (sel)
            0:       return {a_so, a_sv, a_ls, a_lr};
            1:       return {b_so, b_sv, b_ls, b_lr};
            default: return {c_so, c_sv, c_ls, c_lr};
        endcase
    endfunction

    task automatic expect_outs(input int sel, input string tag,
                               input logic s, input logic v, input logic l, input logic r);
        logic [3:0] o;
        o = outs(sel);
        check({tag, ".sout"},  32'(o[3]), 32'(s));
        check({tag, ".valid"}, 32'(o[2]), 32'(v));
        check({tag, ".last"},  32'(o[1]), 32'(l));
        check({tag, ".ready"}, 32'(o[0]), 32'(r));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic [4:0] w, input logic lv);
        if (sel == 0) begin
            a_I = w; a_lv = lv;
        end else begin
            b_I = w; b_lv = lv;
        end
    endtask

    // Accept one word on an idle n=5 instance and check all five bits plus the idle after.
    task automatic send_word(input int sel, input string tag, input logic [4:0] w, input bit msb);
        logic [4:0] wv;
        logic       eb;
        wv = w;
        drive(sel, wv, 1'b1);
        #1;
        check({tag, ".accept_rdy"}, 32'(outs(sel) & 4'b0001), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            drive(sel, 5'b00000, 1'b0);
            #1;
            eb = msb ? wv[4-k] : wv[k];
            expect_outs(sel, $sformatf("%s.b%0d", tag, k), eb, 1'b1, k == 4, k == 4);
        end
        step();
        #1;
        expect_outs(sel, {tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e10;
        logic [2:0] e6;
        rst  = 1'b1;
        a_I  = '0; b_I = '0; c_I = '0;
        a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;

        // Reset state; load_ready held low while reset is asserted, even with load_valid
        step();
        a_lv = 1'b1; a_I = 5'b11111;
        step();
        expect_outs(0, "rst.a", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_outs(1, "rst.b", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_outs(2, "rst.c", 1'b0, 1'b0, 1'b0, 1'b0);
        a_lv = 1'b0;
        rst  = 1'b0;
        #1;
        expect_outs(0, "rst_rel.a", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_outs(2, "rst_rel.c", 1'b0, 1'b0, 1'b0, 1'b1);

        // MSB-first: 10110 -> 1,0,1,1,0
        send_word(0, "t1", 5'b10110, 1'b1);

        // LSB-first: 10110 -> 0,1,1,0,1
        send_word(1, "t2", 5'b10110, 1'b0);

        // Back-to-back words with load_valid held high
        e10 = 10'b10101_11010;
        a_I = 5'b10101; a_lv = 1'b1;
        #1;
        for (int j = 0; j < 10; j++) begin
            step();
            if (j == 4) a_I = 5'b11010;
            if (j == 5) a_lv = 1'b0;
            #1;
            expect_outs(0, $sformatf("t3.b%0d", j), e10[9-j], 1'b1,
                        (j == 4) || (j == 9), (j == 4) || (j == 9));
        end
        step();
        #1;
        expect_outs(0, "t3.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Load presented while busy is held off until the last-bit edge
        a_I = 5'b00000; a_lv = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) a_lv = 1'b0;
            else begin
                a_lv = 1'b1; a_I = 5'b11111;
            end
            #1;
            expect_outs(0, $sformatf("t4.w0b%0d", k), 1'b0, 1'b1, k == 4, k == 4);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) a_lv = 1'b0;
            #1;
            expect_outs(0, $sformatf("t4.w1b%0d", k), 1'b1, 1'b1, k == 4, k == 4);
        end
        step();
        #1;
        expect_outs(0, "t4.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset pulse after two bits aborts the frame; a load offered during reset is dropped
        a_I = 5'b11010; a_lv = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            step();
            if (k == 0) a_lv = 1'b0;
            else begin
                rst = 1'b1; a_lv = 1'b1; a_I = 5'b11111;
            end
            #1;
            expect_outs(0, $sformatf("t5.b%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step();
        rst = 1'b0; a_lv = 1'b0;
        #1;
        expect_outs(0, "t5.abort", 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(0, "t5.new", 5'b01101, 1'b1);

        // n=1: one word per cycle, last on every valid bit
        e6 = 3'b101;
        c_I = 1'b1; c_lv = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) c_I = e6[1-k];
            else c_lv = 1'b0;
            #1;
            expect_outs(2, $sformatf("t6.b%0d", k), e6[2-k], 1'b1, 1'b1, 1'b1);
        end
        step();
        #1;
        expect_outs(2, "t6.idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
